multicycle_memory: RTL

Word-addressed, single-port data memory that is the responder side of the CPU memory bus. It sits directly below the memory arbiter and accepts one access per cycle on MEM_EN/WR/addr. Writes commit in one cycle; reads return data after a fixed, pipelined latency, flagged by a one-cycle data_valid pulse. The same block backs both instruction-fill and data-fill traffic.

---
 rtl/mem_pkg.sv | 16 +
 rtl/multicycle_memory_if.sv | 44 ++++
 rtl/mem_lat_pipe.sv | 42 ++++
 rtl/multicycle_memory.sv | 83 ++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, latency bounds and bus op encoding for the memory bus
//
// Imported by the memory responder and the arbiter so that both ends agree on
// the address/data widths and on the meaning of the WR bit.
package mem_pkg;

  localparam int MEM_ADDR_W          = 16;
  localparam int MEM_DATA_W          = 16;
  localparam int MEM_LATENCY_DEFAULT = 4;
  localparam int MEM_LATENCY_MAX     = 8;

  // Bus op encoding carried on WR
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage : mem_pkg

// File: rtl/multicycle_memory_if.sv
// rtl/multicycle_memory_if.sv - memory bus bundle between arbiter (master) and memory (slave)
//
// Signals:
//   MEM_EN      access request, one per cycle
//   WR          OP_WRITE / OP_READ
//   addr        byte address, word index = addr[ADDR_W-1:1]
//   data_in     write data
//   data_out    read data, zero unless data_valid
//   data_valid  one-cycle pulse per completed read
//   addr_err    misaligned-access pulse (only with MEM_ADDR_CHECK_EN)
interface multicycle_memory_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic              MEM_EN;
  logic              WR;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
`ifdef MEM_ADDR_CHECK_EN
  logic              addr_err;
`endif

  modport master (
    output MEM_EN, WR, addr, data_in,
`ifdef MEM_ADDR_CHECK_EN
    input  addr_err,
`endif
    input  data_out, data_valid
  );

  modport slave (
    input  MEM_EN, WR, addr, data_in,
`ifdef MEM_ADDR_CHECK_EN
    output addr_err,
`endif
    output data_out, data_valid
  );

endinterface : multicycle_memory_if

// File: rtl/mem_lat_pipe.sv
// rtl/mem_lat_pipe.sv - LATENCY-deep {valid, data} shift register with async active-low clear
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low clear of every stage
//   valid_i      stage-0 valid
//   data_i       stage-0 data
//   valid_o      final-stage valid (registered)
//   data_o       final-stage data (registered)
module mem_lat_pipe #(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [LATENCY-1:0]             valid_q;
  logic [LATENCY-1:0][DATA_W-1:0] data_q;

  // No stall: every stage advances each cycle; in-flight entries vanish on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule : mem_lat_pipe

// File: rtl/multicycle_memory.sv
// rtl/multicycle_memory.sv - word-addressed single-port data memory with pipelined fixed-latency reads
//
// Optional feature macro: MEM_ADDR_CHECK_EN (misaligned-access detection, addr_err port).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears the read pipeline, not the array)
//   bus    multicycle_memory_if.slave: MEM_EN, WR, addr, data_in in;
//          data_out, data_valid (and addr_err) out
module multicycle_memory
  import mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY_DEFAULT,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_memory_if.slave bus
);

  localparam int WORD_AW = ADDR_W - 1;
  localparam int WORDS   = 1 << WORD_AW;

  logic [DATA_W-1:0]  mem_q [WORDS];
  logic [WORD_AW-1:0] word_idx;
  logic               misaligned;
  logic               rd_issue;
  logic               wr_commit;
  logic [DATA_W-1:0]  pipe_data_d;

  assign word_idx = bus.addr[ADDR_W-1:1];

`ifdef MEM_ADDR_CHECK_EN
  logic addr_err_q;

  assign misaligned = bus.addr[0];

  // One-cycle registered flag in the cycle after a misaligned access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= bus.MEM_EN && misaligned;
    end
  end

  assign bus.addr_err = addr_err_q;
`else
  logic unused_addr0;

  assign unused_addr0 = bus.addr[0];
  assign misaligned   = 1'b0;
`endif

  assign rd_issue  = bus.MEM_EN && (bus.WR == OP_READ);
  assign wr_commit = bus.MEM_EN && (bus.WR == OP_WRITE) && !misaligned;

  // Array is not reset. A read sampled on the same edge as nothing else sees
  // every write made on an earlier edge; the write lands at the end of its edge.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem_q[word_idx] <= bus.data_in;
    end
  end

  // Bubbles and misaligned reads carry zero data so data_out is zero
  // whenever data_valid is low, and zero for a flagged read.
  assign pipe_data_d = (rd_issue && !misaligned) ? mem_q[word_idx] : '0;

  mem_lat_pipe #(
    .LATENCY (LATENCY),
    .DATA_W  (DATA_W)
  ) u_lat_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (rd_issue),
    .data_i  (pipe_data_d),
    .valid_o (bus.data_valid),
    .data_o  (bus.data_out)
  );

endmodule : multicycle_memory
